// File: rtl/reg_pkg.sv
// Shared constants and types for the general-purpose register file.
// The destination selector uses the same $0/$29/$31 constants.
package reg_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [ADDR_W-1:0]                 reg_addr_t;
    typedef logic [DATA_W-1:0]                 reg_data_t;
    typedef logic [NUM_REGS-1:0][DATA_W-1:0]   reg_array_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP   = 5'd29;
    localparam reg_addr_t REG_RA   = 5'd31;

    localparam reg_data_t SP_RESET_DEFAULT = 32'd227;

endpackage

// File: rtl/reg_bank_if.sv
// Register-file access bundle: one write port and two read ports.
//   master : datapath side, drives addresses / write data, receives read data
//   slave  : register file side
interface reg_bank_if;
    import reg_pkg::*;

    logic      RegWrite;
    reg_addr_t ReadReg1;
    reg_addr_t ReadReg2;
    reg_addr_t WriteReg;
    reg_data_t WriteData;
    reg_data_t ReadData1;
    reg_data_t ReadData2;

    modport master (
        output RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData,
        output ReadData1, ReadData2
    );

endinterface

// File: rtl/reg_bank_rdport.sv
// One combinational read port of the register file.
// Ports:
//   addr    : read address
//   regs    : current storage contents
//   wr_en   : write active this cycle (already masked by reset)
//   wr_addr : write address
//   wr_data : write data, forwarded when BYPASS is set
//   data    : read result
module reg_bank_rdport
    import reg_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  reg_addr_t  addr,
    input  reg_array_t regs,
    input  logic       wr_en,
    input  reg_addr_t  wr_addr,
    input  reg_data_t  wr_data,
    output reg_data_t  data
);

    // $0 is hardwired; forwarding wins over storage for the register being written
    always_comb begin
        data = regs[addr];
        if (addr == REG_ZERO) begin
            data = '0;
        end else if (BYPASS && wr_en && (addr == wr_addr)) begin
            data = wr_data;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// 32 x 32 general-purpose register file, two read ports, one write port.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; clears all entries, $29 <- SP_RESET
//   bus   : slave side of reg_bank_if (RegWrite, ReadReg1/2, WriteReg,
//           WriteData in; ReadData1/2 out, combinational)
module reg_bank
    import reg_pkg::*;
#(
    parameter reg_data_t SP_RESET = SP_RESET_DEFAULT,
    parameter bit        BYPASS   = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    reg_bank_if.slave    bus
);

    reg_array_t regs;
    logic       wr_en;

    // A reset cycle discards any write, including its forwarded value
    assign wr_en = bus.RegWrite && !reset;

    // Storage update; $0 is never written so it stays at its reset value of zero
    always_ff @(posedge clk) begin
        if (reset) begin
            regs         <= '0;
            regs[REG_SP] <= SP_RESET;
        end else if (wr_en && (bus.WriteReg != REG_ZERO)) begin
            regs[bus.WriteReg] <= bus.WriteData;
        end
    end

    reg_bank_rdport #(.BYPASS(BYPASS)) u_rdport1 (
        .addr    (bus.ReadReg1),
        .regs    (regs),
        .wr_en   (wr_en),
        .wr_addr (bus.WriteReg),
        .wr_data (bus.WriteData),
        .data    (bus.ReadData1)
    );

    reg_bank_rdport #(.BYPASS(BYPASS)) u_rdport2 (
        .addr    (bus.ReadReg2),
        .regs    (regs),
        .wr_en   (wr_en),
        .wr_addr (bus.WriteReg),
        .wr_data (bus.WriteData),
        .data    (bus.ReadData2)
    );

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: one instance with bypass, one without,
// driven by the same directed vectors.
module tb_reg_bank;
    import reg_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    logic      reg_write;
    reg_addr_t rd1_addr, rd2_addr, wr_addr;
    reg_data_t wr_data;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string     name;
        int        sel;   // 0:byp.rd1 1:byp.rd2 2:nobyp.rd1 3:nobyp.rd2
        reg_data_t exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    reg_bank_if bus_b ();
    reg_bank_if bus_n ();

    assign bus_b.RegWrite  = reg_write;
    assign bus_b.ReadReg1  = rd1_addr;
    assign bus_b.ReadReg2  = rd2_addr;
    assign bus_b.WriteReg  = wr_addr;
    assign bus_b.WriteData = wr_data;
    assign bus_n.RegWrite  = reg_write;
    assign bus_n.ReadReg1  = rd1_addr;
    assign bus_n.ReadReg2  = rd2_addr;
    assign bus_n.WriteReg  = wr_addr;
    assign bus_n.WriteData = wr_data;

    reg_bank #(.SP_RESET(32'd227), .BYPASS(1'b1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    reg_bank #(.SP_RESET(32'd227), .BYPASS(1'b0)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n.slave)
    );

    function automatic reg_data_t pick(input int sel);
        case (sel)
            0:       return bus_b.ReadData1;
            1:       return bus_b.ReadData2;
            2:       return bus_n.ReadData1;
            default: return bus_n.ReadData2;
        endcase
    endfunction

    // Monitor: outputs are combinational, so every cycle's expectations are
    // checked mid-cycle, well away from the active edge
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            reg_data_t act;
            e   = sb.pop_front();
            act = pick(e.sel);
            tests_run++;
            if (act !== e.exp) begin
                tests_failed++;
                $display("FAIL %s port%0d: got %h expected %h", e.name, e.sel, act, e.exp);
            end
        end
    end

    task automatic push(input string name, input int sel, input reg_data_t exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Drive one cycle's inputs just after the rising edge
    task automatic step(input logic rst, input logic rw, input reg_addr_t a1,
                        input reg_addr_t a2, input reg_addr_t wa, input reg_data_t wd);
        @(posedge clk);
        #1;
        reset     = rst;
        reg_write = rw;
        rd1_addr  = a1;
        rd2_addr  = a2;
        wr_addr   = wa;
        wr_data   = wd;
    endtask

    initial begin
        reset = 1'b1; reg_write = 1'b0;
        rd1_addr = '0; rd2_addr = '0; wr_addr = '0; wr_data = '0;

        // Reset, then sweep every address on both instances
        step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        for (int a = 0; a < 32; a++) begin
            step(1'b0, 1'b0, 5'(a), 5'(a), 5'd0, 32'h0);
            push("reset_sweep", 0, (a == 29) ? 32'd227 : 32'd0);
            push("reset_sweep", 1, (a == 29) ? 32'd227 : 32'd0);
            push("reset_sweep", 2, (a == 29) ? 32'd227 : 32'd0);
            push("reset_sweep", 3, (a == 29) ? 32'd227 : 32'd0);
        end

        // Write $8, visible next cycle; $9 untouched
        step(1'b0, 1'b1, 5'd8, 5'd9, 5'd8, 32'hDEADBEEF);
        push("wr8_same_cycle", 0, 32'hDEADBEEF);
        push("wr8_same_cycle", 2, 32'h0);
        step(1'b0, 1'b0, 5'd8, 5'd8, 5'd0, 32'h0);
        push("rd8", 0, 32'hDEADBEEF);
        push("rd8", 1, 32'hDEADBEEF);
        push("rd8", 3, 32'hDEADBEEF);
        step(1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 32'h0);
        push("rd9", 0, 32'h0);
        push("rd9", 3, 32'h0);

        // Writes to $0 are ignored, bypass never applies to $0
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
        push("zero_wr_cycle", 0, 32'h0);
        push("zero_wr_cycle", 1, 32'h0);
        push("zero_wr_cycle", 3, 32'h0);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        push("zero_after", 0, 32'h0);
        push("zero_after", 1, 32'h0);
        push("zero_after", 2, 32'h0);

        // Bypass on $31: forwarded vs. stored-old, then both show the new value
        step(1'b0, 1'b1, 5'd8, 5'd31, 5'd31, 32'h12345678);
        push("byp31", 1, 32'h12345678);
        push("nobyp31_old", 3, 32'h0);
        push("rd8_during_wr31", 0, 32'hDEADBEEF);
        step(1'b0, 1'b0, 5'd31, 5'd31, 5'd0, 32'h0);
        push("rd31_after", 1, 32'h12345678);
        push("rd31_after", 3, 32'h12345678);

        // Reset priority over a simultaneous write to $29
        step(1'b0, 1'b1, 5'd29, 5'd29, 5'd29, 32'h77);
        step(1'b0, 1'b0, 5'd29, 5'd29, 5'd0, 32'h0);
        push("sp_written", 0, 32'h77);
        push("sp_written", 3, 32'h77);
        step(1'b1, 1'b1, 5'd29, 5'd29, 5'd29, 32'd5);
        push("rst_cycle_no_byp", 0, 32'h77);
        push("rst_cycle_no_byp", 2, 32'h77);
        step(1'b0, 1'b0, 5'd29, 5'd8, 5'd0, 32'h0);
        push("rst_prio_sp", 0, 32'd227);
        push("rst_prio_sp", 2, 32'd227);
        push("rst_clears8", 1, 32'h0);
        push("rst_clears8", 3, 32'h0);

        // Back-to-back writes to $29, last wins; others unchanged
        step(1'b0, 1'b1, 5'd29, 5'd8, 5'd29, 32'd1);
        push("b2b_1_byp", 0, 32'd1);
        push("b2b_1_nobyp", 2, 32'd227);
        step(1'b0, 1'b1, 5'd29, 5'd8, 5'd29, 32'd2);
        push("b2b_2_byp", 0, 32'd2);
        push("b2b_2_nobyp", 2, 32'd1);
        step(1'b0, 1'b1, 5'd29, 5'd8, 5'd29, 32'd3);
        push("b2b_3_byp", 0, 32'd3);
        push("b2b_3_nobyp", 2, 32'd2);
        push("b2b_other8", 1, 32'h0);
        step(1'b0, 1'b0, 5'd29, 5'd31, 5'd0, 32'h0);
        push("b2b_final", 0, 32'd3);
        push("b2b_final", 2, 32'd3);
        push("b2b_other31", 1, 32'h0);
        push("b2b_other31", 3, 32'h0);

        // Let the monitor drain, then confirm nothing was left unchecked
        @(posedge clk);
        @(posedge clk);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
# reg_bank

General-purpose register file of the multicycle MIPS datapath: 32 registers × 32 bits, two read ports, one write port. It is the consumer of the write-destination address chosen by the register-destination selector (rt, rd, $29, $31 or rs). It supplies operands A/B to the datapath registers. Writes commit on the clock edge; reads are combinational, with an optional same-cycle write bypass.

## Interface
Parameters:
- SP_RESET, 32'd227: reset value of $29 (stack pointer).
- BYPASS, 1: when 1, a read of the register being written in the same cycle returns WriteData. When 0, it returns the stored value.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- RegWrite  input  1  write enable for the current cycle.
- ReadReg1  input  5  address for read port 1 (rs).
- ReadReg2  input  5  address for read port 2 (rt).
- WriteReg  input  5  write address (output of the destination selector).
- WriteData  input  32  data to write.
- ReadData1  output  32  contents of ReadReg1.
- ReadData2  output  32  contents of ReadReg2.

## Operation
- Storage: 32 entries × 32 bits, indices 0–31.
- Reset, sampled at a rising edge with reset=1:
  - All entries become 0, except entry 29, which becomes SP_RESET.
  - Reset has priority over RegWrite; any write in a reset cycle is discarded.
- Write: at a rising edge with reset=0 and RegWrite=1, entry[WriteReg] ← WriteData.
  - WriteReg=0 is ignored; entry 0 is never modified.
- Read, for each port independently:
  - Address 0 → 32'd0 always, regardless of bypass.
  - If BYPASS=1, RegWrite=1, reset=0, the address is nonzero and equals WriteReg → WriteData.
  - Otherwise → entry[address].
- Both ports may read the same address; both return identical data.
- A value of X or Z on an unused address input must not corrupt stored state. Only WriteReg/RegWrite gate the write.

## Timing
- Read latency: 0 cycles (combinational from address and storage).
- Write latency: 1 edge. With BYPASS=0, the new value is visible on a read port in the cycle after the write edge.
- Outputs after reset:
  - ReadData1/ReadData2 = 0 for every address except 29, which returns SP_RESET.
  - No output is registered, so output values follow the addresses immediately.
- Reset mid-operation: a reset at any edge overrides an in-flight write. State is fully reinitialised in one cycle, with no multi-cycle clear.
- Back-to-back writes to the same register on consecutive edges: the last one wins. No write is merged or dropped.
- Writing $29 or $31, as selected for stack or link operations, behaves like any other nonzero register.

## Structure
- Shared package (reg_pkg):
  - REG_ZERO=5'd0, REG_SP=5'd29, REG_RA=5'd31.
  - Register address width 5; data width 32.
  - Default SP reset value 227.
  - The destination selector uses the same constants for its $29/$31 selections.
- Sub-module reg_bank_rdport: one instance per read port. It performs the zero-register check, the bypass compare and the storage mux. The storage array and write logic stay in reg_bank.
- Expected size: 120–200 lines of RTL.

## Test plan
- Reset check: assert reset for 1 edge, then sweep ReadReg1 over 0–31 → 0 for every address except 29, which reads 227. ReadData2 matches for the same sweep.
- Write/read: write 32'hDEADBEEF to $8. Next cycle, read $8 on both ports → 32'hDEADBEEF on both. $9 still reads 0.
- Zero register: write 32'hFFFFFFFF to $0 → $0 reads 0 on both ports, in the write cycle and in the following cycle.
- Bypass:
  - BYPASS=1: in the cycle writing 32'h12345678 to $31 with ReadReg2=31, ReadData2 = 32'h12345678 before the edge.
  - BYPASS=0: in the same cycle ReadData2 shows the old value; the next cycle it shows 32'h12345678.
- Reset priority: assert reset together with RegWrite=1, WriteReg=29, WriteData=5 → $29 reads 227 afterwards, not 5.
- Consecutive writes: write 1, 2, 3 to $29 on three successive edges → $29 reads 1, 2, 3 in the cycles after each edge. Other registers are unchanged.
